// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared types and helpers for the sync_fifo write arbiter
package sync_fifo_pkg;
  typedef enum logic {ARB, LOCKED} arb_state_t;
  function automatic int unsigned depth_of(input int unsigned depth_bits);
    return 32'd1 << depth_bits;
  endfunction
  function automatic int unsigned last_grant_reset(input int unsigned num_requesters);
    return num_requesters - 1;
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set request bit searching cyclically upward from start
module rr_priority_pick #(
  parameter int n = 4
) (
  input  logic [n-1:0]         req,
  input  logic [$clog2(n)-1:0] start,
  output logic                 found,
  output logic [$clog2(n)-1:0] index
);
  localparam int iw = $clog2(n);
  int j;
  always_comb begin
    found = 1'b0;
    index = '0;
    j = 0;
    for (int k = n - 1; k >= 0; k--) begin
      j = (int'(start) + k) % n;
      if (req[j]) begin
        found = 1'b1;
        index = iw'(j);
      end
    end
  end
endmodule

// File: rtl/sync_fifo_write_arbiter.sv
// sync_fifo_write_arbiter: round-robin, packet-locking arbiter driving one sync_fifo write port
module sync_fifo_write_arbiter
  import sync_fifo_pkg::*;
#(
  parameter int num_requesters = 4,
  parameter int input_width = 8,
  parameter int depth_bits = 8
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [num_requesters-1:0]             req_valid,
  input  logic [num_requesters-1:0]             req_last,
  input  logic [num_requesters*input_width-1:0] req_data,
  output logic [num_requesters-1:0]             req_ready,
  output logic                                  fifo_write_enable,
  output logic [input_width-1:0]                fifo_data_in,
  input  logic                                  fifo_read_enable,
  output logic [depth_bits:0]                   count,
  output logic                                  full,
  output logic                                  empty,
  output logic [$clog2(num_requesters)-1:0]     grant_id
);
  localparam int gw = $clog2(num_requesters);
  localparam int cw = depth_bits + 1;
  arb_state_t state, state_next;
  logic [gw-1:0] owner, last_grant, start, index;
  logic [num_requesters-1:0] cand;
  logic found, accept;
  assign full = !reset && count + cw'(fifo_write_enable) == cw'(depth_of(depth_bits));
  assign empty = reset || count == '0;
  assign start = state == LOCKED ? owner : last_grant == gw'(num_requesters - 1) ? '0 : last_grant + gw'(1);
  assign cand = state == LOCKED ? req_valid & (num_requesters'(1) << owner) : req_valid;
  rr_priority_pick #(.n(num_requesters)) u_pick (.req(cand), .start(start), .found(found), .index(index));
  assign req_ready = found && !full && !reset ? num_requesters'(1) << index : '0;
  assign accept = |req_ready;
  always_comb state_next = accept ? (req_last[index] ? ARB : LOCKED) : state;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ARB;
      owner <= '0;
      last_grant <= gw'(last_grant_reset(num_requesters));
      grant_id <= '0;
      fifo_write_enable <= 1'b0;
      fifo_data_in <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      fifo_write_enable <= accept;
      count <= count + cw'(fifo_write_enable) - cw'(fifo_read_enable && count != '0);
      if (accept) begin
        owner <= index;
        last_grant <= index;
        grant_id <= index;
        fifo_data_in <= req_data[index*input_width +: input_width];
      end
    end
  end
endmodule

// File: tb/tb_sync_fifo_write_arbiter.sv
// tb_sync_fifo_write_arbiter: scoreboard bench against a behavioural arbiter model
module tb_sync_fifo_write_arbiter;
  localparam int N = 4, W = 8, DB = 2, DEPTH = 4;
  logic clock = 1'b0, reset = 1'b1;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [N*W-1:0] req_data = '0;
  logic fifo_write_enable, fifo_read_enable = 1'b0, full, empty;
  logic [W-1:0] fifo_data_in;
  logic [DB:0] count;
  logic [1:0] grant_id;
  int errors = 0, checks = 0;
  logic [9:0] exp_q[$];
  int m_count = 0, m_last = N - 1, m_owner = 0;
  bit m_locked = 1'b0, m_inflight = 1'b0, rand_len = 1'b0;
  int len[N] = '{default: 1};
  int beat[N] = '{default: 0};
  always #5 clock = ~clock;
  sync_fifo_write_arbiter #(.num_requesters(N), .input_width(W), .depth_bits(DB)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_write_enable(fifo_write_enable), .fifo_data_in(fifo_data_in),
    .fifo_read_enable(fifo_read_enable), .count(count), .full(full), .empty(empty), .grant_id(grant_id)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  always @(negedge clock) begin
    if (fifo_write_enable === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write: unexpected id=%0d data=%0h at %0t", grant_id, fifo_data_in, $time);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({grant_id, fifo_data_in} !== e) begin
          errors++;
          $display("FAIL write: got id=%0d data=%0h expected id=%0d data=%0h at %0t",
                   grant_id, fifo_data_in, e[9:8], e[7:0], $time);
        end
      end
    end
  end
  task automatic step(input logic [N-1:0] v, input bit rd, input bit rst);
    logic [N-1:0] e_rdy;
    bit mf;
    int w;
    @(negedge clock);
    reset = rst;
    req_valid = v;
    fifo_read_enable = rd;
    for (int i = 0; i < N; i++) begin
      req_last[i] = beat[i] == len[i] - 1;
      req_data[i*W +: W] = W'($urandom);
    end
    #1;
    mf = !rst && (m_count + int'(m_inflight) == DEPTH);
    e_rdy = '0;
    w = -1;
    if (!rst && !mf) begin
      if (m_locked) begin
        if (v[m_owner]) w = m_owner;
      end else begin
        for (int k = 1; k <= N && w < 0; k++)
          if (v[(m_last + k) % N]) w = (m_last + k) % N;
      end
    end
    if (w >= 0) e_rdy[w] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(e_rdy));
    check("full", 32'(full), 32'(mf));
    check("empty", 32'(empty), 32'(rst || m_count == 0));
    check("count", 32'(count), m_count);
    check("write_enable", 32'(fifo_write_enable), 32'(m_inflight));
    if (rst) begin
      m_count = 0;
      m_inflight = 1'b0;
      m_locked = 1'b0;
      m_last = N - 1;
      for (int i = 0; i < N; i++) beat[i] = 0;
    end else begin
      m_count = m_count + int'(m_inflight) - ((rd && m_count > 0) ? 1 : 0);
      m_inflight = w >= 0;
      if (w >= 0) begin
        exp_q.push_back({2'(w), req_data[w*W +: W]});
        m_last = w;
        m_owner = w;
        m_locked = !req_last[w];
        if (req_last[w]) begin
          beat[w] = 0;
          if (rand_len) len[w] = $urandom_range(1, 4);
        end else beat[w]++;
      end
    end
  endtask
  initial begin
    repeat (2) step('0, 1'b0, 1'b1);
    repeat (8) step(4'hf, 1'b1, 1'b0);
    len[2] = 3;
    step(4'b0100, 1'b1, 1'b0);
    repeat (2) step(4'b0111, 1'b1, 1'b0);
    step(4'hf, 1'b1, 1'b0);
    repeat (6) step('0, 1'b1, 1'b0);
    repeat (7) step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    repeat (3) step(4'b0001, 1'b0, 1'b0);
    repeat (6) step('0, 1'b1, 1'b0);
    repeat (2) step(4'b0001, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0);
    repeat (5) step('0, 1'b1, 1'b0);
    len[1] = 4;
    step(4'b0010, 1'b1, 1'b0);
    step('0, 1'b0, 1'b1);
    len[1] = 1;
    repeat (2) step(4'b1010, 1'b1, 1'b0);
    step('0, 1'b0, 1'b1);
    step(4'b1011, 1'b1, 1'b0);
    len[0] = 3;
    step(4'b0001, 1'b1, 1'b0);
    repeat (5) step(4'b1110, 1'b1, 1'b0);
    repeat (4) step(4'hf, 1'b1, 1'b0);
    rand_len = 1'b1;
    repeat (400) step(N'($urandom), 1'($urandom), $urandom_range(0, 63) == 0);
    rand_len = 1'b0;
    repeat (6) step('0, 1'b1, 1'b0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
